pwm_servo_multi: RTL

PWM_SERVO_MULTI -- requirements
Module: pwm_servo_multi

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_channel.sv | 51 +++++
 rtl/pwm_servo_multi.sv | 81 ++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: default timing/match constants and the command-to-match clamp helpers
// shared by pwm_servo_multi and its channels.
package pwm_pkg;
  localparam int DEF_PERIOD        = 606;
  localparam int DEF_MIN_MATCH     = 229;
  localparam int DEF_MAX_MATCH     = 371;
  localparam int DEF_DEFAULT_MATCH = 300;
  localparam int DEF_IN_LIMIT      = 200;

  function automatic logic match_ok(input int unsigned data, input int unsigned m,
                                    input int unsigned limit, input int unsigned lo,
                                    input int unsigned hi);
    return data < limit && m >= lo && m <= hi;
  endfunction

  function automatic int unsigned clamp_match(input int unsigned data, input int unsigned m,
                                              input int unsigned limit, input int unsigned lo,
                                              input int unsigned hi, input int unsigned dflt);
    return match_ok(data, m, limit, lo, hi) ? m : dflt;
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one channel's shadow/active match pair, frame-boundary load and compare.
// With PWM_SLEW_EN defined the load moves active toward shadow by at most SLEW_STEP.
module pwm_channel #(
  parameter int CNT_W         = 10,
  parameter int DEFAULT_MATCH = 300,
  parameter int SLEW_STEP     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);
`ifdef PWM_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif
  // a step wider than any match value makes the slew path a plain copy
  localparam int STEP = SLEW_EN ? SLEW_STEP : (1 << CNT_W);

  logic [CNT_W-1:0] shadow_q, shadow_d, active_q, active_d, next_active;
  logic             pwm_q, pwm_d;
  logic [CNT_W:0]   a, s, st;

  always_comb begin
    a           = {1'b0, active_q};
    s           = {1'b0, shadow_q};
    st          = (CNT_W+1)'(STEP);
    next_active = (s > a + st) ? CNT_W'(a + st) : (a > s + st) ? CNT_W'(a - st) : shadow_q;
    shadow_d    = wr ? wr_val : shadow_q;
    active_d    = load ? next_active : active_q;
    pwm_d       = cnt < active_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= CNT_W'(DEFAULT_MATCH);
      active_q <= CNT_W'(DEFAULT_MATCH);
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm = pwm_q;
endmodule

// File: rtl/pwm_servo_multi.sv
// pwm_servo_multi: multi-channel servo PWM with a shared frame counter and shadowed
// per-channel match registers. Optional PWM_SLEW_EN enables per-frame slew limiting.
module pwm_servo_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int IN_W          = 8,
  parameter int CNT_W         = 10,
  parameter int PERIOD        = DEF_PERIOD,
  parameter int SCALE_SHIFT   = 1,
  parameter int IN_LIMIT      = DEF_IN_LIMIT,
  parameter int MIN_MATCH     = DEF_MIN_MATCH,
  parameter int MAX_MATCH     = DEF_MAX_MATCH,
  parameter int DEFAULT_MATCH = DEF_DEFAULT_MATCH,
  parameter int SLEW_STEP     = 8,
  localparam int CH_W         = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [IN_W-1:0]   cmd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic              cmd_err
);
  logic [CNT_W-1:0]  cnt_q, cnt_d, wr_val;
  logic              frame_start_q, frame_start_d, cmd_err_q, cmd_err_d;
  logic              last, accept, ch_ok, data_ok;
  logic [CNT_W:0]    m;
  logic [NUM_CH-1:0] sel, wr;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) sel[i] = cmd_ch == CH_W'(i);
    last          = cnt_q == CNT_W'(PERIOD - 1);
    accept        = cmd_valid && !last;
    ch_ok         = |sel;
    m             = (CNT_W+1)'(cmd_data) << SCALE_SHIFT;
    data_ok       = match_ok(32'(cmd_data), 32'(m), IN_LIMIT, MIN_MATCH, MAX_MATCH);
    wr_val        = CNT_W'(clamp_match(32'(cmd_data), 32'(m), IN_LIMIT, MIN_MATCH, MAX_MATCH,
                                       DEFAULT_MATCH));
    wr            = accept ? sel : '0;
    cnt_d         = last ? '0 : cnt_q + CNT_W'(1);
    frame_start_d = cnt_q == '0;
    cmd_err_d     = accept && !(ch_ok && data_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_MATCH(DEFAULT_MATCH),
      .SLEW_STEP    (SLEW_STEP)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr[c]),
      .wr_val(wr_val),
      .load  (last),
      .cnt   (cnt_q),
      .pwm   (pwm_out[c])
    );
  end

  assign cmd_ready   = !last;
  assign frame_start = frame_start_q;
  assign cmd_err     = cmd_err_q;
endmodule
